// File: rtl/mio_pkg.sv
// Shared types and constants for the memory-mapped I/O bridge.
package mio_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAM_WAIT = 2'd1,
      RESP     = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REG_RAM = 2'd0,
      REG_IO  = 2'd1,
      REG_ERR = 2'd2
   } region_t;

   localparam logic [31:0] LED_OFS = 32'h0000_0000;
   localparam logic [31:0] SW_OFS  = 32'h0000_0004;
   localparam logic [31:0] CNT_OFS = 32'h0000_0008;

endpackage

// File: rtl/mio_counter.sv
// Free-running 32-bit cycle counter; a load replaces the increment for that edge.
module mio_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   output logic [31:0] count
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   // Next count: load has priority over the free-running increment.
   always_comb begin
      count_d = count_q + 32'd1;
      if (load) begin
         count_d = load_val;
      end else begin
         count_d = count_q + 32'd1;
      end
   end

   // Counter state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/mio_bridge.sv
// CPU data-port bridge: decodes word requests to the data RAM or the LED/SW/counter
// registers and sequences the one-cycle RAM read latency.
module mio_bridge
   import mio_pkg::*;
#(
   parameter int          RAM_AW  = 10,
   parameter logic [31:0] IO_BASE = 32'hF000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CPU_MIO,
   input  logic              MemRW,
   input  logic [31:0]       Addr_out,
   input  logic [31:0]       Data_out,
   output logic [31:0]       Data_in,
   output logic              MIO_ready,
   output logic              bus_err,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   input  logic [15:0]       sw,
   output logic [15:0]       led
);

   localparam logic [32:0] RAM_LIMIT = 33'd4 << RAM_AW;

   state_t      state_q;
   logic [31:0] data_in_q;
   logic        ready_q;
   logic        err_q;
   logic [15:0] led_q;

   region_t     region_s;
   logic [31:0] io_ofs_s;
   logic [31:0] io_rdata_s;
   logic        accept_s;
   logic        cnt_load_s;
   logic [31:0] count_s;

   // Region decode and register read mux for the presented address.
   always_comb begin
      region_s   = REG_ERR;
      io_ofs_s   = Addr_out - IO_BASE;
      io_rdata_s = 32'd0;
      if (Addr_out[1:0] != 2'b00) begin
         region_s = REG_ERR;
      end else if ({1'b0, Addr_out} < RAM_LIMIT) begin
         region_s = REG_RAM;
      end else if (io_ofs_s == LED_OFS || io_ofs_s == SW_OFS || io_ofs_s == CNT_OFS) begin
         region_s = REG_IO;
      end else begin
         region_s = REG_ERR;
      end
      case (io_ofs_s)
         LED_OFS: io_rdata_s = {16'd0, led_q};
         SW_OFS:  io_rdata_s = {16'd0, sw};
         CNT_OFS: io_rdata_s = count_s;
         default: io_rdata_s = 32'd0;
      endcase
   end

   // A request is taken only in IDLE and never while reset is asserted.
   assign accept_s   = !rst && (state_q == IDLE) && CPU_MIO;
   assign cnt_load_s = accept_s && (region_s == REG_IO) && MemRW && (io_ofs_s == CNT_OFS);

   assign ram_addr = Addr_out[RAM_AW+1:2];
   assign ram_din  = Data_out;
   assign ram_we   = accept_s && (region_s == REG_RAM) && MemRW;

   mio_counter u_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load_s),
      .load_val (Data_out),
      .count    (count_s)
   );

   // Request sequencer with registered completion, error and read-data outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         data_in_q <= 32'd0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         led_q     <= 16'd0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (CPU_MIO) begin
                  if (region_s == REG_RAM && !MemRW) begin
                     state_q <= RAM_WAIT;
                  end else begin
                     state_q   <= RESP;
                     ready_q   <= 1'b1;
                     err_q     <= (region_s == REG_ERR);
                     data_in_q <= (region_s == REG_IO && !MemRW) ? io_rdata_s : 32'd0;
                     if (region_s == REG_IO && MemRW && io_ofs_s == LED_OFS) begin
                        led_q <= Data_out[15:0];
                     end else begin
                        led_q <= led_q;
                     end
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            RAM_WAIT: begin
               data_in_q <= ram_dout;
               ready_q   <= 1'b1;
               state_q   <= RESP;
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Data_in   = data_in_q;
   assign MIO_ready = ready_q;
   assign bus_err   = err_q;
   assign led       = led_q;

endmodule

// File: tb/tb_mio_bridge.sv
// Directed, table-driven bench for mio_bridge with a behavioural synchronous RAM.
module tb_mio_bridge;

   logic        clk;
   logic        rst;
   logic        CPU_MIO;
   logic        MemRW;
   logic [31:0] Addr_out;
   logic [31:0] Data_out;
   logic [31:0] Data_in;
   logic        MIO_ready;
   logic        bus_err;
   logic [9:0]  ram_addr;
   logic        ram_we;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;
   logic [15:0] sw;
   logic [15:0] led;

   int n_cmp;
   int n_fail;
   int cyc;
   int ready_cyc;

   logic [31:0] mem [0:1023];

   mio_bridge #(.RAM_AW(10), .IO_BASE(32'hF000_0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .CPU_MIO   (CPU_MIO),
      .MemRW     (MemRW),
      .Addr_out  (Addr_out),
      .Data_out  (Data_out),
      .Data_in   (Data_in),
      .MIO_ready (MIO_ready),
      .bus_err   (bus_err),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .sw        (sw),
      .led       (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [15:0] sw;
      int          lat;
      logic        err;
      logic        chk;
      logic [31:0] dat;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request (called #1 after a rising edge) and check the response.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_err, input logic chk_data,
                         input logic [31:0] exp_data, input string nm);
      int   lat;
      int   wes;
      bit   got;
      logic err_seen;
      logic [31:0] dat_seen;
      logic exp_we;
      CPU_MIO  = 1'b1;
      MemRW    = we;
      Addr_out = addr;
      Data_out = wdata;
      got = 0; wes = 0; lat = -1; err_seen = 1'b0; dat_seen = 32'd0;
      for (int k = 0; k < 6 && !got; k++) begin
         @(negedge clk);
         if (ram_we) begin
            wes++;
            chk({nm, " ram_addr"}, {22'd0, ram_addr}, {22'd0, addr[11:2]});
         end
         if (MIO_ready) begin
            got = 1; lat = k; ready_cyc = cyc;
            err_seen = bus_err; dat_seen = Data_in;
         end
         tick();
      end
      CPU_MIO = 1'b0;
      exp_we = we && !exp_err && (addr < 32'h0000_1000);
      chk({nm, " latency"}, lat, exp_lat);
      chk({nm, " bus_err"}, {31'd0, err_seen}, {31'd0, exp_err});
      chk({nm, " ram_we pulses"}, wes, {31'd0, exp_we});
      if (chk_data) chk({nm, " Data_in"}, dat_seen, exp_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] v1;
      logic [31:0] v2;
      int base;
      n_cmp = 0; n_fail = 0; cyc = 0; ready_cyc = 0;
      rst = 1'b1; CPU_MIO = 1'b0; MemRW = 1'b0; Addr_out = 32'd0; Data_out = 32'd0; sw = 16'd0;

      vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 16'h0000, 1, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h0000, 2, 1'b0, 1'b1, 32'h1234_5678};
      vecs[2]  = '{1'b1, 32'hF000_0000, 32'h0000_A5A5, 16'h0000, 1, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 32'hF000_0000, 32'h0,         16'h0000, 1, 1'b0, 1'b1, 32'h0000_A5A5};
      vecs[4]  = '{1'b0, 32'hF000_0004, 32'h0,         16'h00FF, 1, 1'b0, 1'b1, 32'h0000_00FF};
      vecs[5]  = '{1'b1, 32'hF000_0004, 32'h0000_1234, 16'h00FF, 1, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 32'h0000_0012, 32'h0,         16'h00FF, 1, 1'b1, 1'b1, 32'h0};
      vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         16'h00FF, 1, 1'b1, 1'b1, 32'h0};
      vecs[8]  = '{1'b1, 32'h8000_0000, 32'hDEAD_0000, 16'h00FF, 1, 1'b1, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 16'h00FF, 1, 1'b0, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 32'h0000_0FFC, 32'h0,         16'h00FF, 2, 1'b0, 1'b1, 32'hDEAD_BEEF};
      vecs[11] = '{1'b0, 32'h0000_1000, 32'h0,         16'h00FF, 1, 1'b1, 1'b1, 32'h0};

      // Reset state.
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset MIO_ready", {31'd0, MIO_ready}, 32'd0);
      chk("reset bus_err", {31'd0, bus_err}, 32'd0);
      chk("reset ram_we", {31'd0, ram_we}, 32'd0);
      chk("reset led", {16'd0, led}, 32'd0);
      chk("reset Data_in", Data_in, 32'd0);
      tick();

      for (int i = 0; i < 12; i++) begin
         sw = vecs[i].sw;
         do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].err,
                vecs[i].chk, vecs[i].dat, $sformatf("vec%0d", i));
      end
      chk("led after table", {16'd0, led}, 32'h0000_A5A5);

      // LED visible from cycle 1.
      CPU_MIO = 1'b1; MemRW = 1'b1; Addr_out = 32'hF000_0000; Data_out = 32'h0000_C3C3;
      @(negedge clk);
      chk("led cycle0", {16'd0, led}, 32'h0000_A5A5);
      tick();
      @(negedge clk);
      chk("led cycle1", {16'd0, led}, 32'h0000_C3C3);
      chk("led write ready", {31'd0, MIO_ready}, 32'd1);
      tick();
      CPU_MIO = 1'b0;

      // Counter wrap: load FFFF_FFFE, read in the fourth cycle after the load edge.
      do_req(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, 1, 1'b0, 1'b0, 32'h0, "cnt load");
      tick(); tick();
      do_req(1'b0, 32'hF000_0008, 32'h0, 1, 1'b0, 1'b1, 32'h0000_0001, "cnt wrap");

      // Two back-to-back counter reads are two cycles apart.
      do_req(1'b0, 32'hF000_0008, 32'h0, 1, 1'b0, 1'b0, 32'h0, "cnt rd1");
      v1 = Data_in;
      do_req(1'b0, 32'hF000_0008, 32'h0, 1, 1'b0, 1'b0, 32'h0, "cnt rd2");
      v2 = Data_in;
      chk("cnt delta", v2 - v1, 32'd2);

      // Reset during RAM_WAIT drops the access.
      CPU_MIO = 1'b1; MemRW = 1'b0; Addr_out = 32'h0000_0010;
      tick();
      rst = 1'b1; CPU_MIO = 1'b0;
      @(negedge clk);
      chk("rst ram_wait ready", {31'd0, MIO_ready}, 32'd0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post-rst MIO_ready", {31'd0, MIO_ready}, 32'd0);
         chk("post-rst bus_err", {31'd0, bus_err}, 32'd0);
         if (k == 0) begin
            chk("post-rst Data_in", Data_in, 32'd0);
            chk("post-rst led", {16'd0, led}, 32'd0);
            chk("post-rst ram_we", {31'd0, ram_we}, 32'd0);
         end
         tick();
      end
      do_req(1'b0, 32'h0000_0010, 32'h0, 2, 1'b0, 1'b1, 32'h1234_5678, "read after rst");

      // Reset and request in the same cycle: request not accepted.
      rst = 1'b1; CPU_MIO = 1'b1; MemRW = 1'b1; Addr_out = 32'hF000_0000; Data_out = 32'h0000_1111;
      @(negedge clk);
      chk("rst+req ram_we", {31'd0, ram_we}, 32'd0);
      tick();
      rst = 1'b0; CPU_MIO = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst+req ready", {31'd0, MIO_ready}, 32'd0);
         chk("rst+req led", {16'd0, led}, 32'd0);
         tick();
      end

      // Back-to-back: LED write, RAM read, counter read -> ready at 1, 4, 6.
      base = cyc;
      do_req(1'b1, 32'hF000_0000, 32'h0000_5A5A, 1, 1'b0, 1'b0, 32'h0, "b2b led");
      chk("b2b ready1", ready_cyc - base, 32'd1);
      do_req(1'b0, 32'h0000_0010, 32'h0, 2, 1'b0, 1'b1, 32'h1234_5678, "b2b ram");
      chk("b2b ready2", ready_cyc - base, 32'd4);
      do_req(1'b0, 32'hF000_0008, 32'h0, 1, 1'b0, 1'b0, 32'h0, "b2b cnt");
      chk("b2b ready3", ready_cyc - base, 32'd6);
      chk("b2b led", {16'd0, led}, 32'h0000_5A5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
